instr_mem_loadable: RTL

Parametrised, loadable instruction memory for the pipelined core's fetch stage. It replaces the fixed, combinationally-read program store. On reset release it self-initialises from a boot image, then serves registered fetches. Between runs a loader can overwrite the program through a word-serial load port.

---
 rtl/instr_mem_pkg.sv | 30 +++
 rtl/instr_mem_array.sv | 39 +++
 rtl/instr_mem_loadable.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and boot image for the loadable instruction memory.
// The boot image is what INIT writes into the store after every reset release.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    READY = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [7:0]  NOP_CODE_DEF = 8'h00;
  localparam int unsigned BOOT_LEN     = 6;

  // addi R2,3 / sll R2,1 / addi R5,4 / jmp 2 / sll R5,3 / addi R1,2
  localparam logic [7:0] BOOT_IMAGE [BOOT_LEN] = '{
    8'h13, 8'h51, 8'h2C, 8'hC2, 8'h6B, 8'h0A
  };

  // Boot word for address idx; addresses past the image read as nop.
  function automatic logic [7:0] boot_word(input int unsigned idx, input logic [7:0] nop);
    logic [2:0] sel;
    sel = idx[2:0];
    if (idx < BOOT_LEN) begin
      return BOOT_IMAGE[sel];
    end else begin
      return nop;
    end
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Single-port instruction storage: synchronous write, registered read.
// The storage itself is never reset; only the read register is.
module instr_mem_array #(
  parameter int IW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [IW-1:0]            wdata,
  output logic [IW-1:0]            rdata
);

  logic [IW-1:0] mem_r [DEPTH];
  logic [IW-1:0] rdata_r;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register only updates on a read, so it holds across stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {IW{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: boots from BOOT_IMAGE, serves registered
// fetches, and accepts word-serial program loads between runs.
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int            IW       = 8,
  parameter int            DEPTH    = 8,
  parameter int            AW       = 8,
  parameter logic [IW-1:0] NOP_CODE = IW'(NOP_CODE_DEF)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] PC,
  input  logic          Fetch_En,
  output logic [IW-1:0] Instruction_Code,
  output logic          Instr_Valid,
  output logic          Addr_Err,
  output logic          Ready,
  input  logic          Load_Start,
  input  logic          Load_Valid,
  input  logic [IW-1:0] Load_Data,
  input  logic          Load_Last,
  output logic          Load_Done
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  state_t        state_r, next_s;
  logic [PW-1:0] ptr_r, addr_s;
  logic [IW-1:0] wdata_s, rdata_s;
  logic          we_s, re_s, fetch_s, done_s, in_range_s;
  logic          ready_r, valid_r, err_r, done_r, nop_sel_r;

  assign in_range_s = (32'(PC) < 32'(DEPTH));

  instr_mem_array #(.IW(IW), .DEPTH(DEPTH)) u_mem (
    .clk   (Clk),
    .rst_n (Reset),
    .we    (we_s),
    .re    (re_s),
    .addr  (addr_s),
    .wdata (wdata_s),
    .rdata (rdata_s)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= INIT;
    end else begin
      state_r <= next_s;
    end
  end

  // Next state and memory port control; Load_Start beats a same-cycle fetch.
  always_comb begin
    next_s  = state_r;
    we_s    = 1'b0;
    re_s    = 1'b0;
    addr_s  = ptr_r;
    wdata_s = NOP_CODE;
    fetch_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      INIT: begin
        we_s    = 1'b1;
        wdata_s = IW'(boot_word(32'(ptr_r), 8'(NOP_CODE)));
        if (ptr_r == LAST) begin
          next_s = READY;
        end else begin
          next_s = INIT;
        end
      end
      READY: begin
        if (Load_Start) begin
          next_s = LOAD;
        end else if (Fetch_En) begin
          fetch_s = 1'b1;
          re_s    = in_range_s;
          addr_s  = PC[PW-1:0];
        end else begin
          next_s = READY;
        end
      end
      LOAD: begin
        if (Load_Valid) begin
          we_s    = 1'b1;
          wdata_s = Load_Data;
          if (Load_Last || (ptr_r == LAST)) begin
            done_s = 1'b1;
            next_s = READY;
          end else begin
            next_s = LOAD;
          end
        end else begin
          next_s = LOAD;
        end
      end
      default: begin
        next_s = INIT;
      end
    endcase
  end

  // Shared init/load pointer; saturates at the last word instead of wrapping.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ptr_r <= {PW{1'b0}};
    end else if ((state_r == READY) && Load_Start) begin
      ptr_r <= {PW{1'b0}};
    end else if (we_s && (ptr_r != LAST)) begin
      ptr_r <= ptr_r + PW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Output registers; nop_sel_r masks the read data outside valid fetches.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ready_r   <= 1'b0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      done_r    <= 1'b0;
      nop_sel_r <= 1'b1;
    end else begin
      ready_r <= (next_s == READY);
      valid_r <= fetch_s;
      done_r  <= done_s;
      if (fetch_s) begin
        nop_sel_r <= !in_range_s;
        err_r     <= !in_range_s;
      end else if (state_r != READY) begin
        nop_sel_r <= 1'b1;
        err_r     <= err_r;
      end else begin
        nop_sel_r <= nop_sel_r;
        err_r     <= err_r;
      end
    end
  end

  assign Instruction_Code = nop_sel_r ? NOP_CODE : rdata_s;
  assign Instr_Valid      = valid_r;
  assign Addr_Err         = err_r;
  assign Ready            = ready_r;
  assign Load_Done        = done_r;

endmodule
